// File: rtl/vector_alu_issue.sv
// Two-stage issue/collect front end for the per-thread vector ALU.
// Optional sticky overflow trap: define VALU_OVERFLOW_TRAP_EN.
package valu_pkg;
   localparam int WORD_W = 32;
   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLL = 4'd5,
      ALU_SRL = 4'd6,
      ALU_SRA = 4'd7
   } aluop_t;
endpackage

interface vector_alu_if #(parameter int THREADS = 4);
   valu_pkg::aluop_t [THREADS-1:0]             op;
   logic [THREADS-1:0][valu_pkg::WORD_W-1:0] porta;
   logic [THREADS-1:0][valu_pkg::WORD_W-1:0] portb;
   logic [THREADS-1:0][valu_pkg::WORD_W-1:0] out;
   logic [THREADS-1:0]                       of;
   logic [THREADS-1:0]                       zf;
   logic [THREADS-1:0]                       nf;
   modport cpu (output op, porta, portb,
                input  out, of, zf, nf);
   modport alu (input  op, porta, portb,
                output out, of, zf, nf);
endinterface

module vector_alu_issue
   import valu_pkg::*;
#(
   parameter int THREADS = 4,
   parameter int TAG_W   = 4
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  aluop_t [THREADS-1:0]           req_op,
   input  logic [THREADS-1:0][WORD_W-1:0] req_a,
   input  logic [THREADS-1:0][WORD_W-1:0] req_b,
   input  logic [THREADS-1:0]             req_mask,
   input  logic [TAG_W-1:0]               req_tag,
   vector_alu_if.cpu                      alu,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [THREADS-1:0][WORD_W-1:0] rsp_data,
   output logic [THREADS-1:0]             rsp_zf,
   output logic [THREADS-1:0]             rsp_nf,
   output logic [THREADS-1:0]             rsp_of,
   output logic [THREADS-1:0]             rsp_mask,
   output logic [TAG_W-1:0]               rsp_tag,
   output logic                           rsp_allzero,
   output logic                           rsp_anyof,
   output logic                           busy,
   output logic                           trap,
   output logic [TAG_W-1:0]               trap_tag,
   input  logic                           trap_clr
);
   localparam int OP_W = $bits(aluop_t);

   logic                           s1_valid_q, s1_valid_d;
   logic [THREADS-1:0][OP_W-1:0]   s1_op_q, s1_op_d;
   logic [THREADS-1:0][WORD_W-1:0] s1_a_q, s1_a_d;
   logic [THREADS-1:0][WORD_W-1:0] s1_b_q, s1_b_d;
   logic [THREADS-1:0]             s1_mask_q, s1_mask_d;
   logic [TAG_W-1:0]               s1_tag_q, s1_tag_d;

   logic                           s2_valid_q, s2_valid_d;
   logic [THREADS-1:0][WORD_W-1:0] s2_data_q, s2_data_d;
   logic [THREADS-1:0]             s2_zf_q, s2_zf_d;
   logic [THREADS-1:0]             s2_nf_q, s2_nf_d;
   logic [THREADS-1:0]             s2_of_q, s2_of_d;
   logic [THREADS-1:0]             s2_mask_q, s2_mask_d;
   logic [TAG_W-1:0]               s2_tag_q, s2_tag_d;

   logic s2_free, s1_adv, req_fire, trap_block;

   assign s2_free  = !s2_valid_q || rsp_ready;
   assign s1_adv   = s1_valid_q && s2_free;
   assign req_ready = !RST && (!s1_valid_q || s2_free) && !trap_block;
   assign req_fire = req_valid && req_ready;

`ifdef VALU_OVERFLOW_TRAP_EN
   logic             trap_q, trap_d;
   logic [TAG_W-1:0] trap_tag_q, trap_tag_d;
   logic             cap_anyof;

   assign cap_anyof  = |(alu.of & s1_mask_q);
   assign trap_block = trap_q;
   assign trap       = trap_q;
   assign trap_tag   = trap_tag_q;

   // Sticky trap; a trapping capture beats a same-edge clear.
   always_comb begin
      trap_d     = trap_q;
      trap_tag_d = trap_tag_q;
      if (trap_clr) trap_d = 1'b0;
      if (s1_adv && cap_anyof) begin
         trap_d     = 1'b1;
         trap_tag_d = s1_tag_q;
      end
   end

   // Trap state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         trap_q     <= 1'b0;
         trap_tag_q <= '0;
      end else begin
         trap_q     <= trap_d;
         trap_tag_q <= trap_tag_d;
      end
   end
`else
   logic unused_trap_clr;
   assign unused_trap_clr = trap_clr;
   assign trap_block = 1'b0;
   assign trap       = 1'b0;
   assign trap_tag   = '0;
`endif

   // Drive the ALU from S1; masked lanes get a harmless zero shift.
   always_comb begin
      for (int i = 0; i < THREADS; i++) begin
         if (s1_mask_q[i]) begin
            alu.op[i]    = aluop_t'(s1_op_q[i]);
            alu.porta[i] = s1_a_q[i];
            alu.portb[i] = s1_b_q[i];
         end else begin
            alu.op[i]    = ALU_SLL;
            alu.porta[i] = '0;
            alu.portb[i] = '0;
         end
      end
   end

   // Next state: S1 loads on accept, S2 captures ALU results on advance.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_mask_d  = s1_mask_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_zf_d    = s2_zf_q;
      s2_nf_d    = s2_nf_q;
      s2_of_d    = s2_of_q;
      s2_mask_d  = s2_mask_q;
      s2_tag_d   = s2_tag_q;
      if (s1_adv) s1_valid_d = 1'b0;
      if (req_fire) begin
         s1_valid_d = 1'b1;
         s1_op_d    = req_op;
         s1_a_d     = req_a;
         s1_b_d     = req_b;
         s1_mask_d  = req_mask;
         s1_tag_d   = req_tag;
      end
      if (s2_free) s2_valid_d = s1_valid_q;
      if (s1_adv) begin
         s2_mask_d = s1_mask_q;
         s2_tag_d  = s1_tag_q;
         for (int i = 0; i < THREADS; i++) begin
            s2_data_d[i] = s1_mask_q[i] ? alu.out[i] : '0;
            s2_zf_d[i]   = s1_mask_q[i] & alu.zf[i];
            s2_nf_d[i]   = s1_mask_q[i] & alu.nf[i];
            s2_of_d[i]   = s1_mask_q[i] & alu.of[i];
         end
      end
   end

   // Pipeline registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_mask_q  <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_zf_q    <= '0;
         s2_nf_q    <= '0;
         s2_of_q    <= '0;
         s2_mask_q  <= '0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_mask_q  <= s1_mask_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_zf_q    <= s2_zf_d;
         s2_nf_q    <= s2_nf_d;
         s2_of_q    <= s2_of_d;
         s2_mask_q  <= s2_mask_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign rsp_valid   = s2_valid_q;
   assign rsp_data    = s2_data_q;
   assign rsp_zf      = s2_zf_q;
   assign rsp_nf      = s2_nf_q;
   assign rsp_of      = s2_of_q;
   assign rsp_mask    = s2_mask_q;
   assign rsp_tag     = s2_tag_q;
   assign rsp_allzero = (|s2_mask_q) && (&(s2_zf_q | ~s2_mask_q));
   assign rsp_anyof   = |(s2_of_q & s2_mask_q);
   assign busy        = s1_valid_q || s2_valid_q;
endmodule

// File: tb/tb_vector_alu_issue.sv
// Bench for vector_alu_issue: queue-level model plus directed vectors.
// Also covers the VALU_OVERFLOW_TRAP_EN build.
module tb_vector_alu_issue;
   import valu_pkg::*;
   localparam int T  = 4;
   localparam int TW = 4;
   localparam int W  = 32;

   typedef struct packed {
      logic [W-1:0] out;
      logic         of;
      logic         zf;
      logic         nf;
   } lane_t;

   typedef struct packed {
      logic [T-1:0][W-1:0] data;
      logic [T-1:0]        zf;
      logic [T-1:0]        nf;
      logic [T-1:0]        of;
      logic [T-1:0]        mask;
      logic [TW-1:0]       tag;
      logic                allz;
      logic                anyo;
      logic                aged;
      logic                shown;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst = 1'b1;
   logic                req_valid = 1'b0;
   logic                req_ready;
   aluop_t [T-1:0]      req_op;
   logic [T-1:0][W-1:0] req_a = '0;
   logic [T-1:0][W-1:0] req_b = '0;
   logic [T-1:0]        req_mask = '0;
   logic [TW-1:0]       req_tag = '0;
   logic                rsp_valid;
   logic                rsp_ready = 1'b1;
   logic [T-1:0][W-1:0] rsp_data;
   logic [T-1:0]        rsp_zf, rsp_nf, rsp_of, rsp_mask;
   logic [TW-1:0]       rsp_tag;
   logic                rsp_allzero, rsp_anyof, busy, trap;
   logic [TW-1:0]       trap_tag;
   logic                trap_clr = 1'b0;

   vector_alu_if #(.THREADS(T)) alu_if ();

   vector_alu_issue #(.THREADS(T), .TAG_W(TW)) dut (
      .CLK(clk), .RST(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .req_mask(req_mask), .req_tag(req_tag),
      .alu(alu_if.cpu),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zf(rsp_zf), .rsp_nf(rsp_nf),
      .rsp_of(rsp_of), .rsp_mask(rsp_mask), .rsp_tag(rsp_tag),
      .rsp_allzero(rsp_allzero), .rsp_anyof(rsp_anyof),
      .busy(busy), .trap(trap), .trap_tag(trap_tag),
      .trap_clr(trap_clr)
   );

   // Reference behaviour of the attached per-lane ALU.
   function automatic lane_t alu_ref(input aluop_t op,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
      lane_t r;
      r = '0;
      case (op)
         ALU_ADD: begin
            r.out = a + b;
            r.of  = (a[W-1] == b[W-1]) && (r.out[W-1] != a[W-1]);
         end
         ALU_SUB: begin
            r.out = a - b;
            r.of  = (a[W-1] != b[W-1]) && (r.out[W-1] != a[W-1]);
         end
         ALU_AND: r.out = a & b;
         ALU_OR:  r.out = a | b;
         ALU_XOR: r.out = a ^ b;
         ALU_SLL: r.out = a << b[4:0];
         ALU_SRL: r.out = a >> b[4:0];
         ALU_SRA: r.out = $unsigned($signed(a) >>> b[4:0]);
         default: r.out = '0;
      endcase
      r.zf = (r.out == '0);
      r.nf = r.out[W-1];
      return r;
   endfunction

   for (genvar g = 0; g < T; g++) begin : g_alu
      lane_t r;
      assign r = alu_ref(alu_if.op[g], alu_if.porta[g], alu_if.portb[g]);
      assign alu_if.out[g] = r.out;
      assign alu_if.of[g]  = r.of;
      assign alu_if.zf[g]  = r.zf;
      assign alu_if.nf[g]  = r.nf;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Expected response for one request.
   function automatic ent_t mk(input aluop_t [T-1:0] op,
                               input logic [T-1:0][W-1:0] a,
                               input logic [T-1:0][W-1:0] b,
                               input logic [T-1:0] m,
                               input logic [TW-1:0] tg);
      ent_t e;
      lane_t r;
      e = '0;
      e.mask = m;
      e.tag  = tg;
      for (int i = 0; i < T; i++) begin
         if (m[i]) begin
            r = alu_ref(op[i], a[i], b[i]);
            e.data[i] = r.out;
            e.zf[i]   = r.zf;
            e.nf[i]   = r.nf;
            e.of[i]   = r.of;
         end
      end
      e.allz = (m != '0) && ((e.zf & m) == m);
      e.anyo = (e.of & m) != '0;
      return e;
   endfunction

   function automatic logic rdy_f(input logic r, input logic t,
                                  input int n, input logic rr);
      return !r && !t && (n < 2 || rr);
   endfunction

   // Model: in-order queue of at most two ops; an op is visible
   // once it has been inside the block across at least one edge.
   ent_t          q[$];
   logic          m_trap = 1'b0;
   logic [TW-1:0] m_ttag = '0;
   logic          disp_zero = 1'b1;
   int            cyc = 0;
   logic          chk_en = 1'b0;
   int            log_cyc[$];
   logic [TW-1:0] log_tag[$];

   always @(posedge clk) begin
      ent_t e;
      logic fire, pop;
      cyc++;
      if (rst) begin
         q.delete();
         m_trap = 1'b0;
         m_ttag = '0;
         disp_zero = 1'b1;
      end else begin
         fire = req_valid && rdy_f(rst, m_trap, q.size(), rsp_ready);
         pop  = q.size() > 0 && q[0].aged && rsp_ready;
         if (pop) void'(q.pop_front());
         for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            e.aged = 1'b1;
            q[i] = e;
         end
         if (fire)
            q.push_back(mk(req_op, req_a, req_b, req_mask, req_tag));
`ifdef VALU_OVERFLOW_TRAP_EN
         if (trap_clr) m_trap = 1'b0;
`endif
         if (q.size() > 0 && q[0].aged && !q[0].shown) begin
            e = q[0];
            e.shown = 1'b1;
            q[0] = e;
            disp_zero = 1'b0;
`ifdef VALU_OVERFLOW_TRAP_EN
            if (e.anyo) begin
               m_trap = 1'b1;
               m_ttag = e.tag;
            end
`endif
         end
      end
   end

   // Compare DUT against the model every cycle.
   always @(negedge clk) begin
      ent_t e;
      logic ev;
      if (chk_en) begin
         ev = q.size() > 0 && q[0].aged;
         chk("req_ready", 128'(req_ready),
             128'(rdy_f(rst, m_trap, q.size(), rsp_ready)));
         chk("rsp_valid", 128'(rsp_valid), 128'(ev));
         chk("busy", 128'(busy), 128'(q.size() != 0));
         chk("trap", 128'(trap), 128'(m_trap));
         chk("trap_tag", 128'(trap_tag), 128'(m_ttag));
         e = '0;
         if (ev) e = q[0];
         if (ev || disp_zero) begin
            chk("rsp_data", 128'(rsp_data), 128'(e.data));
            chk("rsp_zf", 128'(rsp_zf), 128'(e.zf));
            chk("rsp_nf", 128'(rsp_nf), 128'(e.nf));
            chk("rsp_of", 128'(rsp_of), 128'(e.of));
            chk("rsp_mask", 128'(rsp_mask), 128'(e.mask));
            chk("rsp_tag", 128'(rsp_tag), 128'(e.tag));
            chk("rsp_allzero", 128'(rsp_allzero), 128'(e.allz));
            chk("rsp_anyof", 128'(rsp_anyof), 128'(e.anyo));
         end
         if (rsp_valid && rsp_ready) begin
            log_cyc.push_back(cyc);
            log_tag.push_back(rsp_tag);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input aluop_t [T-1:0] op,
                       input logic [T-1:0][W-1:0] a,
                       input logic [T-1:0][W-1:0] b,
                       input logic [T-1:0] m,
                       input logic [TW-1:0] tg);
      int n;
      logic acc;
      n = 0;
      acc = 1'b0;
      req_valid = 1'b1;
      req_op = op;
      req_a = a;
      req_b = b;
      req_mask = m;
      req_tag = tg;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = req_ready;
         step();
         n++;
      end
      if (!acc) chk("send_timeout", 128'(acc), 128'(1'b1));
      req_valid = 1'b0;
   endtask

   task automatic sendu(input aluop_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [T-1:0] m,
                        input logic [TW-1:0] tg);
      aluop_t [T-1:0]      ov;
      logic [T-1:0][W-1:0] av, bv;
      for (int i = 0; i < T; i++) begin
         ov[i] = op;
         av[i] = a;
         bv[i] = b;
      end
      send(ov, av, bv, m, tg);
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_wait", 128'(rsp_valid), 128'(1'b1));
   endtask

   initial begin
      aluop_t [T-1:0]      ov;
      logic [T-1:0][W-1:0] av, bv;
      logic [TW-1:0]       tg;
      int                  acc;
      logic                got;

      for (int i = 0; i < T; i++) req_op[i] = ALU_ADD;

      // reset
      step();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_ready", 128'(req_ready), 128'(1'b0));
      chk("rst_valid", 128'(rsp_valid), 128'(1'b0));
      chk("rst_busy", 128'(busy), 128'(1'b0));
      chk("rst_trap", 128'(trap), 128'(1'b0));
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 128'(req_ready), 128'(1'b1));
      step();

      // ADD 5+7 on all lanes, two-cycle latency
      sendu(ALU_ADD, 32'd5, 32'd7, 4'hF, 4'd3);
      @(negedge clk);
      chk("add_lat0", 128'(rsp_valid), 128'(1'b0));
      @(negedge clk);
      chk("add_lat1", 128'(rsp_valid), 128'(1'b1));
      chk("add_data", 128'(rsp_data), {4{32'd12}});
      chk("add_zf", 128'(rsp_zf), 128'(4'h0));
      chk("add_tag", 128'(rsp_tag), 128'(4'd3));
      chk("add_allzero", 128'(rsp_allzero), 128'(1'b0));
      step();

      // SUB 9-9 on lanes 0 and 2
      sendu(ALU_SUB, 32'd9, 32'd9, 4'b0101, 4'd4);
      wait_rsp();
      chk("sub_data", 128'(rsp_data), 128'(0));
      chk("sub_zf", 128'(rsp_zf), 128'(4'b0101));
      chk("sub_allzero", 128'(rsp_allzero), 128'(1'b1));
      step();

      // signed overflow on lane 1
      sendu(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 4'b0010, 4'd5);
      wait_rsp();
      chk("ovf_data", 128'(rsp_data),
          {32'h0, 32'h0, 32'h8000_0000, 32'h0});
      chk("ovf_of", 128'(rsp_of), 128'(4'b0010));
      chk("ovf_nf", 128'(rsp_nf), 128'(4'b0010));
      chk("ovf_anyof", 128'(rsp_anyof), 128'(1'b1));
`ifdef VALU_OVERFLOW_TRAP_EN
      chk("ovf_trap", 128'(trap), 128'(1'b1));
      chk("ovf_trap_tag", 128'(trap_tag), 128'(4'd5));
      chk("ovf_blocked", 128'(req_ready), 128'(1'b0));
      step();
      step();
      @(negedge clk);
      chk("ovf_still_blocked", 128'(req_ready), 128'(1'b0));
      step();
      trap_clr = 1'b1;
      step();
      trap_clr = 1'b0;
      @(negedge clk);
      chk("trap_cleared", 128'(trap), 128'(1'b0));
      chk("trap_clr_ready", 128'(req_ready), 128'(1'b1));
`else
      chk("ovf_no_trap", 128'(trap), 128'(1'b0));
      chk("ovf_ready", 128'(req_ready), 128'(1'b1));
      step();
      trap_clr = 1'b1;
      step();
      trap_clr = 1'b0;
      @(negedge clk);
      chk("trap_tag_zero", 128'(trap_tag), 128'(4'd0));
`endif
      step();

      // all lanes masked: allzero must be 0
      sendu(ALU_AND, 32'd0, 32'd0, 4'b0000, 4'd6);
      wait_rsp();
      chk("m0_allzero", 128'(rsp_allzero), 128'(1'b0));
      chk("m0_zf", 128'(rsp_zf), 128'(4'h0));
      step();

      // undecoded opcode
      sendu(aluop_t'(4'd9), 32'd1, 32'd2, 4'hF, 4'd7);
      wait_rsp();
      chk("undec_data", 128'(rsp_data), 128'(0));
      chk("undec_zf", 128'(rsp_zf), 128'(4'hF));
      chk("undec_allzero", 128'(rsp_allzero), 128'(1'b1));
      step();

      // different op per lane
      ov[0] = ALU_OR;  av[0] = 32'hF0;        bv[0] = 32'h0F;
      ov[1] = ALU_SLL; av[1] = 32'h1;         bv[1] = 32'd4;
      ov[2] = ALU_XOR; av[2] = 32'hAA;        bv[2] = 32'hAA;
      ov[3] = ALU_SRA; av[3] = 32'h8000_0000; bv[3] = 32'd4;
      send(ov, av, bv, 4'hF, 4'd8);
      wait_rsp();
      chk("mix_data", 128'(rsp_data),
          {32'hF800_0000, 32'h0, 32'h10, 32'hFF});
      chk("mix_zf", 128'(rsp_zf), 128'(4'b0100));
      chk("mix_nf", 128'(rsp_nf), 128'(4'b1000));
      step();

      // 8 back-to-back ops
      log_cyc.delete();
      log_tag.delete();
      for (int t = 0; t < 8; t++)
         sendu(ALU_ADD, 32'(t), 32'd1, 4'hF, TW'(t));
      for (int i = 0; i < 4; i++) step();
      chk("stream_count", 128'(log_tag.size()), 128'(8));
      if (log_tag.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("stream_tag", 128'(log_tag[i]), 128'(i));
            chk("stream_cyc", 128'(log_cyc[i] - log_cyc[0]), 128'(i));
         end
      end

      // backpressure: only two ops held
      rsp_ready = 1'b0;
      log_cyc.delete();
      log_tag.delete();
      tg = 4'd10;
      acc = 0;
      req_valid = 1'b1;
      req_mask = 4'hF;
      for (int i = 0; i < T; i++) begin
         req_op[i] = ALU_ADD;
         req_b[i] = 32'd0;
      end
      for (int c = 0; c < 6; c++) begin
         req_tag = tg;
         for (int i = 0; i < T; i++) req_a[i] = 32'(tg);
         @(negedge clk);
         got = req_ready;
         step();
         if (got) begin
            acc++;
            tg = tg + 4'd1;
         end
      end
      chk("bp_accepts", 128'(acc), 128'(2));
      @(negedge clk);
      chk("bp_ready_low", 128'(req_ready), 128'(1'b0));
      chk("bp_hold_tag", 128'(rsp_tag), 128'(4'd10));
      step();
      req_valid = 1'b0;
      step();
      @(negedge clk);
      chk("bp_hold_tag2", 128'(rsp_tag), 128'(4'd10));
      chk("bp_hold_data", 128'(rsp_data), {4{32'd10}});
      step();
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("bp_drain_count", 128'(log_tag.size()), 128'(2));
      if (log_tag.size() == 2) begin
         chk("bp_drain_t0", 128'(log_tag[0]), 128'(4'd10));
         chk("bp_drain_t1", 128'(log_tag[1]), 128'(4'd11));
      end

      // reset with both stages full
      rsp_ready = 1'b0;
      sendu(ALU_ADD, 32'd1, 32'd1, 4'hF, 4'd1);
      sendu(ALU_ADD, 32'd2, 32'd2, 4'hF, 4'd2);
      @(negedge clk);
      chk("full_busy", 128'(busy), 128'(1'b1));
      chk("full_ready", 128'(req_ready), 128'(1'b0));
      step();
      log_cyc.delete();
      log_tag.delete();
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("mid_rst_valid", 128'(rsp_valid), 128'(1'b0));
      chk("mid_rst_busy", 128'(busy), 128'(1'b0));
      chk("mid_rst_data", 128'(rsp_data), 128'(0));
      chk("mid_rst_tag", 128'(rsp_tag), 128'(4'd0));
      chk("mid_rst_trap", 128'(trap), 128'(1'b0));
      chk("mid_rst_ready", 128'(req_ready), 128'(1'b0));
      step();
      rst = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("after_rst_ready", 128'(req_ready), 128'(1'b1));
      for (int i = 0; i < 3; i++) step();
      chk("no_stale_rsp", 128'(log_tag.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/vector_alu_issue.md
# vector_alu_issue

Issue/collect front end for the per-thread vector ALU: accepts one SIMT vector operation per handshake (per-thread op, operands, active mask, tag), drives the combinational vector ALU interface from an operand register, and captures per-thread results and flags into a result register for writeback. Sits between the execute-stage issue logic and the vector ALU, with full-throughput valid/ready pipelining and per-lane masking.

## Interface
- THREADS, 4, number of SIMT lanes; must match the attached vector ALU
- TAG_W, 4, width of the opaque request tag returned with the result
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted on the edge where req_valid && req_ready
- req_op  in  THREADS x aluop_t  per-lane ALU opcode
- req_a, req_b  in  THREADS x WORD_W  per-lane operands
- req_mask  in  THREADS  per-lane active bit
- req_tag  in  TAG_W  returned unchanged
- alu  modport vector_alu_if.cpu  drives op/porta/portb[THREADS]; samples out/of/zf/nf[THREADS]
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts on the edge where rsp_valid && rsp_ready
- rsp_data  out  THREADS x WORD_W  per-lane result
- rsp_zf, rsp_nf, rsp_of  out  THREADS  per-lane flags
- rsp_mask  out  THREADS, rsp_tag  out  TAG_W  copied from request
- rsp_allzero  out  1  every active lane has zf=1 (0 if mask is all-zero)
- rsp_anyof  out  1  any active lane has of=1
- busy  out  1  either stage holds a valid entry
- trap  out  1  sticky overflow trap (see Configuration)
- trap_tag  out  TAG_W  tag of the trapping op
- trap_clr  in  1  clears trap

## Operation
- Two stages: S1 operand register (s1_valid, op, a, b, mask, tag) and S2 result register (s2_valid, data, flags, mask, tag).
- S1 drives alu combinationally. Active lane i: alu.op[i]=op[i], porta/portb=operands. Inactive lane: op=ALU_SLL, porta=portb=0.
- S2 capture: active lanes take alu.out/of/zf/nf; inactive lanes store data=0, zf=nf=of=0.
- rsp_allzero/rsp_anyof computed from S2 flags and mask (combinational from registers).
- Advance rules: s2_free = !s2_valid || rsp_ready; s1 moves to S2 when s1_valid && s2_free; req_ready = (!s1_valid || s2_free) && !trap_block.
- trap_block is 0 unless the trap feature is compiled in.
- Simultaneous accept and advance in one cycle is legal (full throughput, 1 op/cycle).
- aluop_t values not decoded by the ALU produce data 0 and flags from the ALU unchanged (zf=1 for active lanes).

## Timing
- Reset (RST high at edge): s1_valid=s2_valid=0, all rsp_* = 0, trap=0, trap_tag=0, busy=0; req_ready=0 while RST is high, 1 in the first cycle after.
- Latency: request accepted at edge k -> rsp_valid=1 after edge k+1 (2-cycle issue-to-result, one cycle of ALU evaluation).
- rsp_* held stable while rsp_valid && !rsp_ready.
- Backpressure: with rsp_ready=0, at most 2 ops are held; req_ready drops in the cycle both stages are full.
- RST mid-operation discards both stages; no response is produced for in-flight tags.

## Configuration
- VALU_OVERFLOW_TRAP_EN defined: on the edge S2 captures an entry with rsp_anyof=1, trap sets and trap_tag latches that tag. While trap=1, trap_block=1 (no new requests); S1/S2 still drain normally. trap_clr high at an edge clears trap. If trap_clr and a new trapping capture occur on the same edge, the capture wins.
- Not defined: trap and trap_tag are tied 0; trap_clr is ignored; overflow is only reported via rsp_of/rsp_anyof.

## Test plan
- ADD all lanes, a=5, b=7, mask=4'hF, tag=3 -> two cycles later rsp_data=12 per lane, zf=0, tag=3, rsp_allzero=0.
- SUB a=b=9 lanes 0,2 only (mask=4'b0101) -> lanes 0,2 data=0 zf=1; lanes 1,3 data=0 zf=0; rsp_allzero=1.
- ADD lane 1 a=32'h7FFFFFFF b=1 -> rsp_of[1]=1, rsp_nf[1]=1, rsp_anyof=1; with VALU_OVERFLOW_TRAP_EN, trap=1, trap_tag matches, req_ready=0 until trap_clr.
- Stream 8 back-to-back ops with rsp_ready=1 -> 8 responses on consecutive cycles, in order, tags 0..7.
- Hold rsp_ready=0 and keep req_valid=1 -> exactly 2 accepts, then req_ready=0; release -> both drain in order, outputs stable while stalled.
- Assert RST with both stages full -> next cycle rsp_valid=0, busy=0, all outputs 0, trap=0.
